// File: rtl/ms_timer_pkg.sv
// rtl/ms_timer_pkg.sv - shared state encoding for the millisecond countdown timer
package ms_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    EXPIRE = 2'd3
  } state_t;

endpackage

// File: rtl/ms_timer_if.sv
// rtl/ms_timer_if.sv - control/status bundle between a timer client and ms_timer
interface ms_timer_if #(
  parameter int WIDTH = 16
);
  logic             tic;
  logic             load_en;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] remaining;
  logic             busy;
  logic             done;

  modport master (
    output tic, load_en, load_val, start, pause,
    input  remaining, busy, done
  );

  modport slave (
    input  tic, load_en, load_val, start, pause,
    output remaining, busy, done
  );
endinterface

// File: rtl/ms_timer.sv
// rtl/ms_timer.sv - one-shot/periodic millisecond countdown timer driven by an external 1 ms strobe
module ms_timer
  import ms_timer_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  ms_timer_if.slave  bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] reload_q, reload_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      reload_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      reload_q <= reload_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    reload_d = reload_q;
    if (bus.load_en) begin
      rem_d    = bus.load_val;
      reload_d = bus.load_val;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start && (rem_q != '0)) state_d = RUN;
        end
        RUN: begin
          // start is meaningless here, so pause and tic are evaluated as if it were absent
          if (bus.pause) begin
            state_d = PAUSE;
          end else if (bus.tic) begin
            if (rem_q > WIDTH'(1)) begin
              rem_d = rem_q - WIDTH'(1);
            end else begin
              rem_d   = '0;
              state_d = EXPIRE;
            end
          end
        end
        PAUSE: begin
          if (bus.start) state_d = RUN;
        end
        EXPIRE: begin
          if (AUTO_RELOAD && (reload_q != '0)) begin
            rem_d   = reload_q;
            state_d = RUN;
          end else begin
            rem_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A periodic timer is still considered busy during its one-cycle expiry
  assign bus.remaining = rem_q;
  assign bus.done      = (state_q == EXPIRE);
  assign bus.busy      = (state_q == RUN) || (state_q == PAUSE) ||
                         (AUTO_RELOAD && (state_q == EXPIRE));

endmodule

// File: doc/ms_timer.md
MS_TIMER -- requirements
Module: ms_timer

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the bit width of the count value.
REQ-002 Parameter AUTO_RELOAD, default 0, SHALL select one-shot (0) or periodic (1) operation.
REQ-003 Port clk  input  1  SHALL be the system clock; all state changes occur on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset: reset rst, synchronous, active-high.
REQ-005 Port tic  input  1  SHALL be a one-clk-wide 1 ms strobe from the tick generator.
REQ-006 Port load_en  input  1  SHALL capture load_val into the count and reload registers.
REQ-007 Port load_val  input  WIDTH  SHALL be the countdown length in ms.
REQ-008 Port start  input  1  SHALL start the count from IDLE or resume it from PAUSE.
REQ-009 Port pause  input  1  SHALL suspend counting while in RUN.
REQ-010 Port remaining  output  WIDTH  SHALL be the current count value, registered.
REQ-011 Port busy  output  1  SHALL be high in RUN and PAUSE.
REQ-012 Port done  output  1  SHALL pulse for one clk on expiry, registered.

Function
REQ-013 The FSM SHALL have four states: IDLE, RUN, PAUSE, EXPIRE.
REQ-014 Control priority every cycle SHALL be load_en > start > pause > tic.
REQ-015 load_en in any state SHALL set remaining and reload to load_val and go to IDLE next cycle (abort), with no done pulse.
REQ-016 IDLE + start with remaining != 0 SHALL go to RUN; with remaining == 0, start SHALL be ignored.
REQ-017 RUN + tic with remaining > 1 SHALL decrement remaining by 1.
REQ-018 RUN + tic with remaining == 1 SHALL set remaining to 0 and go to EXPIRE.
REQ-019 RUN + pause SHALL go to PAUSE; a tic in the same cycle SHALL be dropped.
REQ-020 PAUSE SHALL ignore tic and hold remaining; start SHALL return to RUN; pause in PAUSE SHALL have no effect.
REQ-021 EXPIRE SHALL last exactly one clk, with done = 1 (Moore output), i.e. one clk after the final tic.
REQ-022 From EXPIRE with AUTO_RELOAD=0, the FSM SHALL go to IDLE with remaining = 0.
REQ-023 From EXPIRE with AUTO_RELOAD=1, the FSM SHALL load remaining from reload and go to RUN, or go to IDLE if reload == 0.
REQ-024 tic in EXPIRE SHALL be dropped; the error of at most one tic per period is accepted.
REQ-025 A tic held high for N consecutive clks SHALL count as N ticks; no edge detection.
REQ-026 remaining SHALL never wrap below 0; a decrement at 0 is impossible by construction.
REQ-027 start in RUN or EXPIRE SHALL be ignored.

Reset
REQ-028 While rst = 1 at a clk edge, the block SHALL set state = IDLE, remaining = 0, reload = 0, done = 0, busy = 0.
REQ-029 rst SHALL override all other inputs, including mid-RUN and in EXPIRE; no done pulse SHALL follow reset.

Structure
REQ-030 Package ms_timer_pkg SHALL hold the state enum typedef (IDLE, RUN, PAUSE, EXPIRE).
REQ-031 The tick source SHALL be external, with no sub-module instantiated; one FSM block plus the count/reload datapath.
REQ-032 busy and done SHALL decode from the registered state only.

Verification
REQ-033 rst for 2 clks mid-RUN (remaining = 7) -> remaining = 0, busy = 0, done = 0; no later done pulse.
REQ-034 load 3, start, 3 tics 10 clks apart -> remaining 3,2,1,0; done high exactly one clk, one clk after the 3rd tic; then IDLE.
REQ-035 load 5, start, 2 tics, pause, 4 tics, start, 3 tics -> remaining holds at 3 during PAUSE; done after the 3rd post-resume tic.
REQ-036 AUTO_RELOAD=1, load 2, start, 6 tics spaced 5 clks -> done pulses after tics 2, 4, 6; busy stays high throughout.
REQ-037 Same-cycle pause + tic in RUN at remaining = 4 -> remaining stays 4, state PAUSE; same-cycle load_en(9) + start -> IDLE with remaining = 9.
REQ-038 load 0, start -> stays IDLE, busy = 0, done never asserts.
